// File: rtl/ram_n_if.sv
// ram_n_if: data/address/control bundle for the ram_n word RAM.
//   in      - write data (WIDTH)
//   address - shared read/write address (ADDR_W)
//   load    - write enable
//   out     - registered read data (WIDTH)
//   busy    - high while the post-reset clear sweep runs
// Modports: master drives in/address/load; slave (the RAM) drives out/busy.
interface ram_n_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 6
);
  logic [WIDTH-1:0]  in;
  logic [ADDR_W-1:0] address;
  logic              load;
  logic [WIDTH-1:0]  out;
  logic              busy;

  modport master (output in, address, load, input out, busy);
  modport slave  (input in, address, load, output out, busy);
endinterface

// File: rtl/ram_n.sv
// ram_n: parametrised synchronous word RAM (DEPTH = 2**ADDR_W words of WIDTH
// bits) with a registered read port and a hardware clear sweep after reset.
// Ports:
//   clk     - single clock, all state changes on the rising edge
//   reset_n - asynchronous active-low reset; restarts the clear sweep
//   bus     - ram_n_if.slave: in, address, load (inputs), out, busy (outputs)
// Build option: define RAM_N_WRITE_FIRST_EN for write-first behaviour (out
// shows the new data on a write edge); default is read-first (old data).
module ram_n #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 6
) (
  input  logic     clk,
  input  logic     reset_n,
  ram_n_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [WIDTH-1:0]  mem [DEPTH];

  // The array has no reset of its own; it is zeroed by the sweep instead,
  // one word per edge, while state is CLEAR.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[ptr] <= '0;
    end else if (bus.load) begin
      mem[bus.address] <= bus.in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= CLEAR;
      ptr      <= '0;
      bus.out  <= '0;
      bus.busy <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          bus.out <= '0;
          // ptr stops at the last word rather than wrapping.
          if (ptr == '1) begin
            state    <= READY;
            bus.busy <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        READY: begin
`ifdef RAM_N_WRITE_FIRST_EN
          bus.out <= bus.load ? bus.in : mem[bus.address];
`else
          // Non-blocking read of mem yields the pre-write word on a write edge.
          bus.out <= mem[bus.address];
`endif
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_n.sv
// tb_ram_n: self-checking bench for ram_n. Two instances run side by side:
// the default 16x64 configuration and an 8-bit x 8-word configuration. A
// reference model (plain arrays plus a remaining-sweep counter) predicts out
// and busy every cycle; directed vectors add hand-computed literal checks.
module tb_ram_n;
`ifdef RAM_N_WRITE_FIRST_EN
  localparam bit WF = 1'b1;
`else
  localparam bit WF = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  ram_n_if #(.WIDTH(16), .ADDR_W(6)) bus_a ();
  ram_n_if #(.WIDTH(8),  .ADDR_W(3)) bus_b ();

  ram_n #(.WIDTH(16), .ADDR_W(6)) dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
  ram_n #(.WIDTH(8),  .ADDR_W(3)) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: reset loses all contents and starts a DEPTH-edge sweep;
  // after that each edge reads (and optionally writes) the array.
  logic [15:0] ma [64];
  logic [15:0] ea_out;
  int          sa_left;
  logic [7:0]  mb [8];
  logic [7:0]  eb_out;
  int          sb_left;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      foreach (ma[i]) ma[i] = '0;
      foreach (mb[i]) mb[i] = '0;
      sa_left = 64;
      sb_left = 8;
      ea_out  = '0;
      eb_out  = '0;
    end else begin
      if (sa_left > 0) begin
        sa_left--;
        ea_out = '0;
      end else begin
        ea_out = (WF && bus_a.load) ? bus_a.in : ma[bus_a.address];
        if (bus_a.load) ma[bus_a.address] = bus_a.in;
      end
      if (sb_left > 0) begin
        sb_left--;
        eb_out = '0;
      end else begin
        eb_out = (WF && bus_b.load) ? bus_b.in : mb[bus_b.address];
        if (bus_b.load) mb[bus_b.address] = bus_b.in;
      end
    end
  end

  always @(negedge clk) begin
    check("model_a_out",  {16'h0, bus_a.out}, {16'h0, ea_out});
    check("model_a_busy", {31'h0, bus_a.busy}, {31'h0, (sa_left > 0)});
    check("model_b_out",  {24'h0, bus_b.out}, {24'h0, eb_out});
    check("model_b_busy", {31'h0, bus_b.busy}, {31'h0, (sb_left > 0)});
  end

  task automatic write_a(input logic [5:0] a, input logic [15:0] d);
    bus_a.address = a; bus_a.in = d; bus_a.load = 1'b1;
    @(negedge clk);
    bus_a.load = 1'b0;
  endtask

  task automatic read_a(input string name, input logic [5:0] a, input logic [15:0] exp);
    bus_a.address = a; bus_a.load = 1'b0;
    @(negedge clk);
    check(name, {16'h0, bus_a.out}, {16'h0, exp});
  endtask

  task automatic write_b(input logic [2:0] a, input logic [7:0] d);
    bus_b.address = a; bus_b.in = d; bus_b.load = 1'b1;
    @(negedge clk);
    bus_b.load = 1'b0;
  endtask

  task automatic read_b(input string name, input logic [2:0] a, input logic [7:0] exp);
    bus_b.address = a; bus_b.load = 1'b0;
    @(negedge clk);
    check(name, {24'h0, bus_b.out}, {24'h0, exp});
  endtask

  // Counts rising edges after reset release until busy is seen low.
  task automatic count_sweep(output int na, output int nb);
    na = 0; nb = 0;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (na == 0 && !bus_a.busy) na = e;
      if (nb == 0 && !bus_b.busy) nb = e;
      if (na != 0 && nb != 0) break;
    end
  endtask

  task automatic async_reset_pulse();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_out_a",  {16'h0, bus_a.out}, 32'h0);
    check("rst_busy_a", {31'h0, bus_a.busy}, 32'h1);
    check("rst_out_b",  {24'h0, bus_b.out}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int na, nb;
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b1;
    bus_a.in = '0; bus_a.address = '0; bus_a.load = 1'b0;
    bus_b.in = '0; bus_b.address = '0; bus_b.load = 1'b0;

    // Reset, then sweep with writes attempted throughout.
    #2 reset_n = 1'b0;
    #1;
    check("init_out_a",  {16'h0, bus_a.out}, 32'h0);
    check("init_busy_a", {31'h0, bus_a.busy}, 32'h1);
    bus_a.load = 1'b1; bus_a.in = 16'hFFFF; bus_a.address = 6'd5;
    @(negedge clk);
    reset_n = 1'b1;
    count_sweep(na, nb);
    bus_a.load = 1'b0;
    check("sweep_len_a", na, 32'd64);
    check("sweep_len_b", nb, 32'd8);
    for (int unsigned i = 0; i < 64; i++) read_a("clear_a", 6'(i), 16'h0);

    // Basic write/read.
    write_a(6'd5, 16'h1234);
    write_a(6'd63, 16'hBEEF);
    read_a("rd5", 6'd5, 16'h1234);
    read_a("rd63", 6'd63, 16'hBEEF);
    read_a("rd0", 6'd0, 16'h0000);

    // Value of out on a write edge.
    write_a(6'd9, 16'h00AA);
    bus_a.address = 6'd9; bus_a.in = 16'h0055; bus_a.load = 1'b1;
    @(negedge clk);
    check("wedge_out", {16'h0, bus_a.out}, WF ? 32'h0055 : 32'h00AA);
    bus_a.load = 1'b0;
    @(negedge clk);
    check("wedge_next", {16'h0, bus_a.out}, 32'h0055);

    // Fill, reset from READY, then reset again mid-sweep.
    for (int unsigned i = 0; i < 64; i++) write_a(6'(i), 16'(i) ^ 16'hA5A5);
    read_a("fill3", 6'd3, 16'hA5A6);
    async_reset_pulse();
    repeat (30) @(posedge clk);
    async_reset_pulse();
    count_sweep(na, nb);
    check("resweep_len_a", na, 32'd64);
    check("resweep_len_b", nb, 32'd8);
    for (int unsigned i = 0; i < 64; i++) read_a("reclear_a", 6'(i), 16'h0);

    // Small configuration: boundary addresses, then random traffic.
    write_b(3'd7, 8'hC3);
    read_b("b_rd7", 3'd7, 8'hC3);
    read_b("b_rd0", 3'd0, 8'h00);
    write_b(3'd0, 8'h3C);
    read_b("b_rd7b", 3'd7, 8'hC3);
    read_b("b_rd0b", 3'd0, 8'h3C);
    for (int unsigned i = 0; i < 40; i++) begin
      bus_b.address = 3'($urandom_range(0, 7));
      bus_b.in      = 8'($urandom_range(0, 255));
      bus_b.load    = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus_b.load = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
